// File: rtl/min_finder_1.sv
// Registered minimum / second-minimum finder over sixteen 4-bit operands.
// A combinational pairwise merge tree feeds a single bank of output registers.
module min_finder_1 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] I0,
  input  logic [3:0] I1,
  input  logic [3:0] I2,
  input  logic [3:0] I3,
  input  logic [3:0] I4,
  input  logic [3:0] I5,
  input  logic [3:0] I6,
  input  logic [3:0] I7,
  input  logic [3:0] I8,
  input  logic [3:0] I9,
  input  logic [3:0] I10,
  input  logic [3:0] I11,
  input  logic [3:0] I12,
  input  logic [3:0] I13,
  input  logic [3:0] I14,
  input  logic [3:0] I15,
  output logic [3:0] min1,
  output logic [3:0] min2,
  output logic [3:0] index_min1,
  output logic       out_valid
);

  typedef struct packed {
    logic [3:0] mn;
    logic [3:0] sec;
    logic [3:0] idx;
  } node_t;

  // Operand a always covers the lower indices, so ties keep a's index.
  function automatic node_t merge_nodes(input node_t a, input node_t b);
    node_t r;
    if (a.mn <= b.mn) begin
      r.mn  = a.mn;
      r.idx = a.idx;
      r.sec = (a.sec <= b.mn) ? a.sec : b.mn;
    end else begin
      r.mn  = b.mn;
      r.idx = b.idx;
      r.sec = (a.mn <= b.sec) ? a.mn : b.sec;
    end
    return r;
  endfunction

  logic [3:0] operand [16];
  node_t      single  [16];
  node_t      lvl1    [8];
  node_t      lvl2    [4];
  node_t      lvl3    [2];
  node_t      root;

  assign operand[0]  = I0;
  assign operand[1]  = I1;
  assign operand[2]  = I2;
  assign operand[3]  = I3;
  assign operand[4]  = I4;
  assign operand[5]  = I5;
  assign operand[6]  = I6;
  assign operand[7]  = I7;
  assign operand[8]  = I8;
  assign operand[9]  = I9;
  assign operand[10] = I10;
  assign operand[11] = I11;
  assign operand[12] = I12;
  assign operand[13] = I13;
  assign operand[14] = I14;
  assign operand[15] = I15;

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      single[k].mn  = operand[k];
      single[k].sec = 4'hF;
      single[k].idx = 4'(k);
    end
  end

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      lvl1[j] = merge_nodes(single[2*j], single[2*j+1]);
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      lvl2[j] = merge_nodes(lvl1[2*j], lvl1[2*j+1]);
    end
  end

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      lvl3[j] = merge_nodes(lvl2[2*j], lvl2[2*j+1]);
    end
  end

  assign root = merge_nodes(lvl3[0], lvl3[1]);

  // Results hold while in_valid is low; out_valid is a one-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min1       <= 4'd0;
      min2       <= 4'd0;
      index_min1 <= 4'd0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        min1       <= root.mn;
        min2       <= root.sec;
        index_min1 <= root.idx;
      end
    end
  end

endmodule

// File: tb/tb_min_finder_1.sv
// Bench for min_finder_1: sort-based reference model, per-cycle compare, directed and random sets.
module tb_min_finder_1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] iv [16];
  logic [3:0] min1, min2, index_min1;
  logic       out_valid;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_min1 = 4'd0, exp_min2 = 4'd0, exp_idx = 4'd0;
  logic       exp_valid = 1'b0;

  min_finder_1 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .I0(iv[0]), .I1(iv[1]), .I2(iv[2]), .I3(iv[3]),
    .I4(iv[4]), .I5(iv[5]), .I6(iv[6]), .I7(iv[7]),
    .I8(iv[8]), .I9(iv[9]), .I10(iv[10]), .I11(iv[11]),
    .I12(iv[12]), .I13(iv[13]), .I14(iv[14]), .I15(iv[15]),
    .min1(min1), .min2(min2), .index_min1(index_min1), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: sort all sixteen values; index is the first position holding the minimum.
  function automatic void model(input logic [3:0] v [16], output logic [3:0] m1,
                                output logic [3:0] m2, output logic [3:0] ix);
    int s [16];
    int t;
    for (int k = 0; k < 16; k++) s[k] = int'(v[k]);
    for (int a = 0; a < 15; a++)
      for (int b = 0; b < 15 - a; b++)
        if (s[b] > s[b+1]) begin
          t = s[b]; s[b] = s[b+1]; s[b+1] = t;
        end
    m1 = 4'(s[0]);
    m2 = 4'(s[1]);
    ix = 4'd0;
    for (int k = 15; k >= 0; k--) if (int'(v[k]) == s[0]) ix = 4'(k);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_min1 = 4'd0; exp_min2 = 4'd0; exp_idx = 4'd0; exp_valid = 1'b0;
    end else begin
      if (in_valid) model(iv, exp_min1, exp_min2, exp_idx);
      exp_valid = in_valid;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_min1", min1, exp_min1);
    chk("model_min2", min2, exp_min2);
    chk("model_idx", index_min1, exp_idx);
    chk("model_valid", {3'd0, out_valid}, {3'd0, exp_valid});
  end

  task automatic lit(input string tag, input int m1, input int m2, input int ix, input int vl);
    chk({tag, "_min1"}, min1, 4'(m1));
    chk({tag, "_min2"}, min2, 4'(m2));
    chk({tag, "_idx"}, index_min1, 4'(ix));
    chk({tag, "_valid"}, {3'd0, out_valid}, 4'(vl));
  endtask

  task automatic set_head(input int a0, input int a1, input int a2, input int a3,
                          input int a4, input int a5, input int rest);
    for (int k = 0; k < 16; k++) iv[k] = 4'(rest);
    iv[0] = 4'(a0); iv[1] = 4'(a1); iv[2] = 4'(a2);
    iv[3] = 4'(a3); iv[4] = 4'(a4); iv[5] = 4'(a5);
  endtask

  // Lets one rising edge pass and lands just after the following falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) iv[k] = 4'd0;
    #1;
    lit("reset", 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back sets, then hold.
    in_valid = 1'b1;
    set_head(2, 3, 1, 2, 5, 6, 9);
    step();
    lit("vec025", 1, 2, 2, 1);
    set_head(5, 2, 10, 0, 4, 1, 9);
    step();
    lit("vec027", 0, 1, 3, 1);
    in_valid = 1'b0;
    set_head(15, 15, 15, 15, 15, 15, 15);
    step();
    lit("hold", 0, 1, 3, 0);

    in_valid = 1'b1;
    set_head(1, 4, 2, 1, 2, 12, 9);
    step();
    lit("vec026", 1, 1, 0, 1);
    for (int k = 0; k < 16; k++) iv[k] = 4'd7;
    iv[15] = 4'd0;
    step();
    lit("last0", 0, 7, 15, 1);
    for (int k = 0; k < 16; k++) iv[k] = 4'd15;
    step();
    lit("allF", 15, 15, 0, 1);
    for (int k = 0; k < 16; k++) iv[k] = 4'd6;
    step();
    lit("all6", 6, 6, 0, 1);

    // Asynchronous reset between edges while out_valid is high.
    set_head(2, 3, 1, 2, 5, 6, 9);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    lit("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    lit("post_rst", 0, 0, 0, 0);

    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < 16; k++)
        iv[k] = (n % 3 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      if (n % 500 == 250) begin
        #2;
        rst = 1'b1;
        #1;
        lit("rand_rst", 0, 0, 0, 0);
        rst = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
